// File: rtl/global_broadcast_unpool.sv
// Replays one buffered per-channel vector as a full IMG_WIDTH x IMG_HEIGHT raster stream.
// A two-entry vector buffer lets the next vector load while the current one streams.
module global_broadcast_unpool #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 7,
    parameter int IMG_WIDTH  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    output logic                           Ready_Out,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    input  logic                           Ready_In,
    output logic                           Row_End_Out,
    output logic                           Last_Out
);
    localparam int VW = DATA_WIDHT * CHANNELS;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [1:0]    occ_q, occ_d;
    logic          rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [VW-1:0] buf_q [2];

    logic push, pop, row_end, last, retire;

    // Handshake outputs come only from registered state.
    assign Ready_Out   = (occ_q < 2'd2);
    assign Valid_Out   = (occ_q != 2'd0);
    assign Data_Out    = buf_q[rd_ptr_q];
    assign row_end     = (col_q == COL_LAST);
    assign last        = row_end && (row_q == ROW_LAST);
    assign Row_End_Out = Valid_Out && row_end;
    assign Last_Out    = Valid_Out && last;

    assign push   = Valid_In && Ready_Out;
    assign pop    = Valid_Out && Ready_In;
    assign retire = pop && last;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        occ_d = occ_q;
        if (pop) begin
            if (row_end) begin
                col_d = '0;
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        case ({push, retire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            col_q <= col_d;
            row_q <= row_d;
            if (push) begin
                buf_q[wr_ptr_q] <= Data_In;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (retire) rd_ptr_q <= ~rd_ptr_q;
        end
    end
endmodule
